adc_serial_controller: RTL and testbench

//  Master-side serial controller for the off-chip ADC. It generates the ADC framing
//  (syncADC), the serial clock (adcSerialClock) and the channel-address bits
//  (adcDataOut). It shifts the returned conversion in from adcDataIn and presents it
//  as a parallel sample with a one-clock valid strobe. It sits between the ADC pins
//  and the sample consumer logic, and runs one conversion per startConversion request.

---
 rtl/adc_serial_controller_if.sv | 27 ++
 rtl/adc_serial_controller.sv | 112 +++++++++++
 tb/tb_adc_serial_controller.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_controller_if.sv
// rtl/adc_serial_controller_if.sv - request, ADC pin and sample signals of the ADC serial controller
interface adc_serial_controller_if #(
  parameter int DATA_BITS = 12
);
  logic                 start_conversion;
  logic [2:0]           channel_select;
  logic                 adc_data_in;
  logic                 adc_serial_clock;
  logic                 sync_adc;
  logic                 adc_data_out;
  logic [DATA_BITS-1:0] sample_data;
  logic [2:0]           sample_channel;
  logic                 sample_valid;
  logic                 busy;

  modport master (
    input  start_conversion, channel_select, adc_data_in,
    output adc_serial_clock, sync_adc, adc_data_out,
    output sample_data, sample_channel, sample_valid, busy
  );

  modport slave (
    output start_conversion, channel_select, adc_data_in,
    input  adc_serial_clock, sync_adc, adc_data_out,
    input  sample_data, sample_channel, sample_valid, busy
  );
endinterface

// File: rtl/adc_serial_controller.sv
// rtl/adc_serial_controller.sv - master-side serial framing, address shift-out and sample capture for the ADC
module adc_serial_controller #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int ADDR_POS   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  adc_serial_controller_if.master  bus
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PER_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [2:0]           ch_lat;
  logic [DATA_BITS-1:0] rx;

  // Command word: channel address MSB first at ADDR_POS, zeros elsewhere.
  function automatic logic cmd_bit(input logic [BW-1:0] k, input logic [2:0] ch);
    int idx;
    idx = int'(k) - ADDR_POS;
    case (idx)
      0:       cmd_bit = ch[2];
      1:       cmd_bit = ch[1];
      2:       cmd_bit = ch[0];
      default: cmd_bit = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      bit_idx              <= '0;
      ch_lat               <= '0;
      rx                   <= '0;
      bus.adc_serial_clock <= 1'b1;
      bus.sync_adc         <= 1'b1;
      bus.adc_data_out     <= 1'b0;
      bus.sample_data      <= '0;
      bus.sample_channel   <= '0;
      bus.sample_valid     <= 1'b0;
      bus.busy             <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_conversion) begin
            state        <= SETUP;
            ch_lat       <= bus.channel_select;
            cnt          <= '0;
            bus.sync_adc <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == HALF_LAST) begin
            state                <= SHIFT;
            cnt                  <= '0;
            bit_idx              <= '0;
            bus.adc_serial_clock <= 1'b0;
            bus.adc_data_out     <= cmd_bit('0, ch_lat);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // cnt spans one full SCLK period: low half, then high half.
          if (cnt == HALF_LAST) begin
            bus.adc_serial_clock <= 1'b1;
            rx                   <= {rx[DATA_BITS-2:0], bus.adc_data_in};
          end
          if (cnt == PER_LAST) begin
            cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              state            <= HOLD;
              bus.adc_data_out <= 1'b0;
            end else begin
              bit_idx              <= bit_idx + 1'b1;
              bus.adc_serial_clock <= 1'b0;
              bus.adc_data_out     <= cmd_bit(bit_idx + 1'b1, ch_lat);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HALF_LAST) begin
            state              <= IDLE;
            cnt                <= '0;
            bus.sync_adc       <= 1'b1;
            bus.busy           <= 1'b0;
            bus.sample_data    <= rx;
            bus.sample_channel <= ch_lat;
            bus.sample_valid   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_serial_controller.sv
// tb/tb_adc_serial_controller.sv - scoreboard bench for adc_serial_controller at CLK_DIV=4 and CLK_DIV=1
module tb_adc_serial_controller;
  localparam int F  = 16;
  localparam int D  = 12;
  localparam int AP = 2;
  localparam int N0 = 2 * 4 * (F + 1);
  localparam int N1 = 2 * 1 * (F + 1);

  typedef struct {
    logic [2:0]   ch;
    logic [D-1:0] word;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb0[$], sb1[$], fr0[$], fr1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_serial_controller_if #(.DATA_BITS(D)) bus0 ();
  adc_serial_controller_if #(.DATA_BITS(D)) bus1 ();

  adc_serial_controller #(.CLK_DIV(4), .FRAME_BITS(F), .DATA_BITS(D), .ADDR_POS(AP)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  adc_serial_controller #(.CLK_DIV(1), .FRAME_BITS(F), .DATA_BITS(D), .ADDR_POS(AP)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [F-1:0] exp_cmd(input logic [2:0] ch);
    logic [F-1:0] c;
    c = '0;
    for (int b = 0; b < 3; b++) c[AP + b] = ch[2 - b];
    return c;
  endfunction

  // ADC model for dut0: serves the queued conversion word and records command bits
  exp_t         cur0 = '{3'd0, '0, 0};
  int           k0 = 0;
  logic [F-1:0] cmd0 = '0;
  bit           in0 = 1'b0;

  always @(negedge bus0.sync_adc) if (rst_n) begin
    check("frame0_expected", 32'(fr0.size() != 0), 32'd1);
    if (fr0.size() != 0) cur0 = fr0.pop_front();
    k0 = 0;
    cmd0 = '0;
    in0 = 1'b1;
  end

  always @(negedge bus0.adc_serial_clock) if (in0) begin
    #1;
    if (k0 < F) cmd0[k0] = bus0.adc_data_out;
    if (k0 >= F - D && k0 < F) bus0.adc_data_in = cur0.word[D - 1 - (k0 - (F - D))];
    else bus0.adc_data_in = 1'($urandom);
    k0++;
  end

  always @(posedge bus0.sync_adc) if (in0) begin
    in0 = 1'b0;
    if (rst_n) begin
      check("sclk_periods0", k0, F);
      check("cmd_bits0", 32'(cmd0), 32'(exp_cmd(cur0.ch)));
    end
  end

  // ADC model for dut1
  exp_t cur1 = '{3'd0, '0, 0};
  int   k1 = 0;
  bit   in1 = 1'b0;

  always @(negedge bus1.sync_adc) if (rst_n) begin
    check("frame1_expected", 32'(fr1.size() != 0), 32'd1);
    if (fr1.size() != 0) cur1 = fr1.pop_front();
    k1 = 0;
    in1 = 1'b1;
  end

  always @(negedge bus1.adc_serial_clock) if (in1) begin
    #1;
    if (k1 >= F - D && k1 < F) bus1.adc_data_in = cur1.word[D - 1 - (k1 - (F - D))];
    else bus1.adc_data_in = 1'($urandom);
    k1++;
  end

  always @(posedge bus1.sync_adc) if (in1) begin
    in1 = 1'b0;
    if (rst_n) check("sclk_periods1", k1, F);
  end

  // Monitors: every sample_valid pops one expected conversion
  always @(negedge clk) if (rst_n && bus0.sample_valid === 1'b1) begin : mon0
    exp_t e;
    if (sb0.size() == 0) check("valid0_expected", 32'd0, 32'd1);
    else begin
      e = sb0.pop_front();
      check("sample_data0", 32'(bus0.sample_data), 32'(e.word));
      check("sample_channel0", 32'(bus0.sample_channel), 32'(e.ch));
      check("valid_cycle0", cyc, e.cyc);
    end
  end

  always @(negedge clk) if (rst_n && bus1.sample_valid === 1'b1) begin : mon1
    exp_t e;
    if (sb1.size() == 0) check("valid1_expected", 32'd0, 32'd1);
    else begin
      e = sb1.pop_front();
      check("sample_data1", 32'(bus1.sample_data), 32'(e.word));
      check("sample_channel1", 32'(bus1.sample_channel), 32'(e.ch));
      check("valid_cycle1", cyc, e.cyc);
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start0(input logic [2:0] ch, input logic [D-1:0] w, output int acc);
    @(negedge clk);
    bus0.start_conversion = 1'b1;
    bus0.channel_select = ch;
    acc = cyc + 1;
    sb0.push_back('{ch, w, acc + N0});
    fr0.push_back('{ch, w, acc + N0});
    @(negedge clk);
    bus0.start_conversion = 1'b0;
    bus0.channel_select = 3'($urandom);
  endtask

  task automatic start1(input logic [2:0] ch, input logic [D-1:0] w, output int acc);
    @(negedge clk);
    bus1.start_conversion = 1'b1;
    bus1.channel_select = ch;
    acc = cyc + 1;
    sb1.push_back('{ch, w, acc + N1});
    fr1.push_back('{ch, w, acc + N1});
    @(negedge clk);
    bus1.start_conversion = 1'b0;
    bus1.channel_select = 3'($urandom);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_sclk"}, 32'(bus0.adc_serial_clock), 32'd1);
    check({tag, "_sync"}, 32'(bus0.sync_adc), 32'd1);
    check({tag, "_dout"}, 32'(bus0.adc_data_out), 32'd0);
    check({tag, "_data"}, 32'(bus0.sample_data), 32'd0);
    check({tag, "_chan"}, 32'(bus0.sample_channel), 32'd0);
    check({tag, "_valid"}, 32'(bus0.sample_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus0.busy), 32'd0);
  endtask

  task automatic do_reset_now();
    rst_n = 1'b0;
    sb0.delete();
    fr0.delete();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, acc2;
    logic [2:0] c1, c2;
    logic [D-1:0] w1, w2;
    bus0.start_conversion = 1'b0; bus0.channel_select = '0; bus0.adc_data_in = 1'b0;
    bus1.start_conversion = 1'b0; bus1.channel_select = '0; bus1.adc_data_in = 1'b0;

    repeat (3) @(negedge clk);
    check_reset0("por");
    rst_n = 1'b1;

    // reset during SETUP, then a normal frame
    start0(3'd3, D'($urandom), acc);
    wait_until(acc + 2);
    check("setup_busy", 32'(bus0.busy), 32'd1);
    check("setup_sync", 32'(bus0.sync_adc), 32'd0);
    #2;
    do_reset_now();
    check_reset0("rst_setup");
    @(negedge clk);
    rst_n = 1'b1;
    start0(3'd6, D'($urandom), acc);
    wait_until(acc + N0 + 2);

    // channel 5, word A5C, with frame-end boundary
    start0(3'd5, 12'hA5C, acc);
    wait_until(acc + N0 - 1);
    check("hold_busy", 32'(bus0.busy), 32'd1);
    check("hold_sync", 32'(bus0.sync_adc), 32'd0);
    wait_until(acc + N0);
    check("end_busy", 32'(bus0.busy), 32'd0);
    check("end_sync", 32'(bus0.sync_adc), 32'd1);
    wait_until(acc + N0 + 2);

    // mid-frame start pulse and channel change are ignored
    c1 = 3'($urandom);
    start0(c1, D'($urandom), acc);
    wait_until(acc + 40);
    bus0.start_conversion = 1'b1;
    bus0.channel_select = ~c1;
    @(negedge clk);
    bus0.start_conversion = 1'b0;
    wait_until(acc + N0 + 20);
    check("ignored_busy", 32'(bus0.busy), 32'd0);
    check("hold_channel", 32'(bus0.sample_channel), 32'(c1));

    // back-to-back frames with start held high
    c1 = 3'($urandom); c2 = 3'($urandom); w1 = D'($urandom); w2 = D'($urandom);
    @(negedge clk);
    bus0.start_conversion = 1'b1;
    bus0.channel_select = c1;
    acc = cyc + 1;
    acc2 = acc + N0 + 1;
    sb0.push_back('{c1, w1, acc + N0});  fr0.push_back('{c1, w1, acc + N0});
    sb0.push_back('{c2, w2, acc2 + N0}); fr0.push_back('{c2, w2, acc2 + N0});
    wait_until(acc + 10);
    bus0.channel_select = c2;
    wait_until(acc + N0 - 1);
    check("b2b_sync_before", 32'(bus0.sync_adc), 32'd0);
    wait_until(acc + N0);
    check("b2b_sync_gap", 32'(bus0.sync_adc), 32'd1);
    wait_until(acc + N0 + 1);
    check("b2b_sync_after", 32'(bus0.sync_adc), 32'd0);
    wait_until(acc2 + 5);
    bus0.start_conversion = 1'b0;
    wait_until(acc2 + N0 + 5);
    check("b2b_idle", 32'(bus0.busy), 32'd0);

    // reset during SHIFT while SCLK is low
    start0(3'($urandom), D'($urandom), acc);
    wait_until(acc + 70);
    check("shift_sclk_low", 32'(bus0.adc_serial_clock), 32'd0);
    #2;
    do_reset_now();
    check_reset0("rst_shift");
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(cyc + 150);
    start0(3'($urandom), D'($urandom), acc);
    wait_until(acc + N0 + 2);

    // randomized frames
    for (int i = 0; i < 4; i++) begin
      start0(3'($urandom), D'($urandom), acc);
      wait_until(acc + N0 + 1 + int'($urandom_range(0, 5)));
    end

    // CLK_DIV=1 instance
    for (int i = 0; i < 3; i++) begin
      start1(3'($urandom), D'($urandom), acc);
      wait_until(acc + N1 - 1);
      check("div1_busy", 32'(bus1.busy), 32'd1);
      wait_until(acc + N1 + 2);
    end

    wait_until(cyc + 20);
    check("sb0_drained", sb0.size(), 32'd0);
    check("sb1_drained", sb1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
